// File: rtl/iq_pkg.sv
// Issue queue shared definitions: entry format, field positions, slot record
// and the CDB snoop helper used for both resident and dispatching entries.
// Optional feature macro: IQ_AGE_SELECT_EN (adds per-slot age for oldest-first select).
package iq_pkg;

  localparam int ENTRY_W      = 139;
  localparam int TAG_W        = 6;
  // Age width is sized for the default depth of 8 entries.
  localparam int IQ_DEPTH_DEF = 8;
  localparam int AGE_W        = $clog2(IQ_DEPTH_DEF);

  localparam int FUNCT3_MSB  = 138;
  localparam int FUNCT3_LSB  = 136;
  localparam int FUNCT7_MSB  = 135;
  localparam int FUNCT7_LSB  = 129;
  localparam int OPCODE_MSB  = 128;
  localparam int OPCODE_LSB  = 122;
  localparam int PRD_MSB     = 121;
  localparam int PRD_LSB     = 116;
  localparam int PRS1_MSB    = 115;
  localparam int PRS1_LSB    = 110;
  localparam int RS1V_MSB    = 109;
  localparam int RS1V_LSB    = 78;
  localparam int PRS2_MSB    = 77;
  localparam int PRS2_LSB    = 72;
  localparam int RS2V_MSB    = 71;
  localparam int RS2V_LSB    = 40;
  localparam int IMM_MSB     = 39;
  localparam int IMM_LSB     = 8;
  localparam int ROB_MSB     = 7;
  localparam int ROB_LSB     = 2;
  localparam int FU_SEL_MSB  = 1;
  localparam int FU_SEL_LSB  = 0;

  typedef struct packed {
    logic               valid;
    logic               rs1_rdy;
    logic               rs2_rdy;
`ifdef IQ_AGE_SELECT_EN
    logic [AGE_W-1:0]   age;
`endif
    logic [ENTRY_W-1:0] payload;
  } iq_slot_t;

  // Returns {ready, value} for one operand after looking at both CDB ports;
  // port 0 has precedence when both carry the awaited tag.
  function automatic logic [32:0] snoop(
    input logic             rdy,
    input logic [TAG_W-1:0] tag,
    input logic [31:0]      val,
    input logic             c0_valid,
    input logic [TAG_W-1:0] c0_tag,
    input logic [31:0]      c0_value,
    input logic             c1_valid,
    input logic [TAG_W-1:0] c1_tag,
    input logic [31:0]      c1_value
  );
    if (rdy)                           return {1'b1, val};
    if (c0_valid && (c0_tag == tag))   return {1'b1, c0_value};
    if (c1_valid && (c1_tag == tag))   return {1'b1, c1_value};
    return {1'b0, val};
  endfunction

endpackage

// File: rtl/iq_select.sv
// Two-winner picker: grant0 is the highest-priority eligible slot, grant1 the
// next one. Priority is lowest index, or highest age when IQ_AGE_SELECT_EN is set.
module iq_select
  import iq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]       eligible,
`ifdef IQ_AGE_SELECT_EN
  input  logic [N*AGE_W-1:0] ages,
`endif
  output logic [N-1:0]       grant0,
  output logic [N-1:0]       grant1
);

`ifdef IQ_AGE_SELECT_EN
  function automatic logic [N-1:0] pick_oldest(input logic [N-1:0] e,
                                               input logic [N*AGE_W-1:0] a);
    logic [N-1:0]     g;
    logic [AGE_W-1:0] best;
    logic             found;
    g     = '0;
    best  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (e[i] && (!found || (a[i*AGE_W +: AGE_W] > best))) begin
        g     = '0;
        g[i]  = 1'b1;
        best  = a[i*AGE_W +: AGE_W];
        found = 1'b1;
      end
    end
    return g;
  endfunction

  assign grant0 = pick_oldest(eligible, ages);
  assign grant1 = pick_oldest(eligible & ~grant0, ages);
`else
  logic [N-1:0] rest;

  // Isolate lowest set bit, then repeat on what remains.
  assign grant0 = eligible & (~eligible + N'(1));
  assign rest   = eligible & ~grant0;
  assign grant1 = rest & (~rest + N'(1));
`endif

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: dispatch into the lowest free slot, CDB wakeup of
// waiting operands, dual issue of ready entries to two functional units.
// Optional feature macro: IQ_AGE_SELECT_EN (oldest-first select instead of slot index).
module issue_queue
  import iq_pkg::*;
#(
  parameter int IQ_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          dispatch_valid,
  input  logic [ENTRY_W-1:0]            dispatch_entry,
  input  logic                          dispatch_rs1_ready,
  input  logic                          dispatch_rs2_ready,
  output logic                          iq_full,
  output logic [$clog2(IQ_DEPTH+1)-1:0] iq_count,
  input  logic                          cdb0_valid,
  input  logic [TAG_W-1:0]              cdb0_tag,
  input  logic [31:0]                   cdb0_value,
  input  logic                          cdb1_valid,
  input  logic [TAG_W-1:0]              cdb1_tag,
  input  logic [31:0]                   cdb1_value,
  output logic [ENTRY_W-1:0]            fu0_entry,
  output logic [ENTRY_W-1:0]            fu1_entry,
  output logic                          fu0_enable,
  output logic                          fu1_enable
);

  localparam int CW    = $clog2(IQ_DEPTH+1);
  localparam int IDX_W = $clog2(IQ_DEPTH);

  iq_slot_t            slot_q [IQ_DEPTH];
  iq_slot_t            slot_d [IQ_DEPTH];
  iq_slot_t            new_slot;
  logic [IQ_DEPTH-1:0] elig, grant0, grant1, issued;
  logic [CW-1:0]       count_q;
  logic [IDX_W-1:0]    free_idx;
  logic                disp_fire;
  logic [ENTRY_W-1:0]  sel0, sel1;
`ifdef IQ_AGE_SELECT_EN
  logic [IQ_DEPTH*AGE_W-1:0] ages;
`endif

  function automatic iq_slot_t wake_slot(input iq_slot_t s);
    iq_slot_t    w;
    logic [32:0] r;
    w = s;
    r = snoop(s.rs1_rdy, s.payload[PRS1_MSB:PRS1_LSB], s.payload[RS1V_MSB:RS1V_LSB],
              cdb0_valid, cdb0_tag, cdb0_value, cdb1_valid, cdb1_tag, cdb1_value);
    w.rs1_rdy = r[32];
    w.payload[RS1V_MSB:RS1V_LSB] = r[31:0];
    r = snoop(s.rs2_rdy, s.payload[PRS2_MSB:PRS2_LSB], s.payload[RS2V_MSB:RS2V_LSB],
              cdb0_valid, cdb0_tag, cdb0_value, cdb1_valid, cdb1_tag, cdb1_value);
    w.rs2_rdy = r[32];
    w.payload[RS2V_MSB:RS2V_LSB] = r[31:0];
    return w;
  endfunction

  assign iq_count  = count_q;
  assign iq_full   = (count_q == CW'(IQ_DEPTH));
  assign disp_fire = dispatch_valid && !iq_full && !flush;
  assign issued    = grant0 | grant1;

  // Eligibility and candidate payloads from registered state only.
  always_comb begin
    sel0 = '0;
    sel1 = '0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      elig[i] = slot_q[i].valid && slot_q[i].rs1_rdy && slot_q[i].rs2_rdy;
      if (grant0[i]) sel0 = sel0 | slot_q[i].payload;
      if (grant1[i]) sel1 = sel1 | slot_q[i].payload;
`ifdef IQ_AGE_SELECT_EN
      ages[i*AGE_W +: AGE_W] = slot_q[i].age;
`endif
    end
    sel0[FU_SEL_MSB:FU_SEL_LSB] = 2'd0;
    sel1[FU_SEL_MSB:FU_SEL_LSB] = 2'd1;
  end

  iq_select #(.N(IQ_DEPTH)) u_select (
    .eligible (elig),
`ifdef IQ_AGE_SELECT_EN
    .ages     (ages),
`endif
    .grant0   (grant0),
    .grant1   (grant1)
  );

  // Lowest-index slot that was free before this edge.
  always_comb begin
    free_idx = '0;
    for (int i = IQ_DEPTH-1; i >= 0; i--) begin
      if (!slot_q[i].valid) free_idx = IDX_W'(i);
    end
  end

  // Next slot state: wakeup, free on issue, age upkeep, then the new dispatch.
  always_comb begin
    new_slot         = '0;
    new_slot.valid   = 1'b1;
    new_slot.rs1_rdy = dispatch_rs1_ready;
    new_slot.rs2_rdy = dispatch_rs2_ready;
    new_slot.payload = dispatch_entry;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      slot_d[i] = wake_slot(slot_q[i]);
      if (issued[i]) slot_d[i].valid = 1'b0;
`ifdef IQ_AGE_SELECT_EN
      // Age counts younger resident entries, so it stays below IQ_DEPTH.
      if (slot_q[i].valid && disp_fire) slot_d[i].age = slot_d[i].age + AGE_W'(1);
      for (int j = 0; j < IQ_DEPTH; j++) begin
        if (issued[j] && (slot_q[j].age < slot_q[i].age))
          slot_d[i].age = slot_d[i].age - AGE_W'(1);
      end
`endif
    end
    if (disp_fire) slot_d[free_idx] = wake_slot(new_slot);
  end

  // State, occupancy and issue registers; reset and flush both squash everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < IQ_DEPTH; i++) slot_q[i].valid <= 1'b0;
      count_q    <= '0;
      fu0_enable <= 1'b0;
      fu1_enable <= 1'b0;
      if (rst) begin
        fu0_entry <= '0;
        fu1_entry <= '0;
      end
    end else begin
      for (int i = 0; i < IQ_DEPTH; i++) slot_q[i] <= slot_d[i];
      count_q    <= count_q + CW'(disp_fire) - CW'(|grant0) - CW'(|grant1);
      fu0_enable <= |grant0;
      fu1_enable <= |grant1;
      if (|grant0) fu0_entry <= sel0;
      if (|grant1) fu1_entry <= sel1;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: a slot/sequence-number reference model
// predicts issues, a monitor compares them as the DUT presents them.
// Optional feature macro: IQ_AGE_SELECT_EN (model switches to oldest-first).
module tb_issue_queue;
  import iq_pkg::*;

  logic               clk = 1'b0;
  logic               rst, flush, dispatch_valid;
  logic [ENTRY_W-1:0] dispatch_entry;
  logic               dispatch_rs1_ready, dispatch_rs2_ready;
  logic               iq_full;
  logic [3:0]         iq_count;
  logic               cdb0_valid, cdb1_valid;
  logic [TAG_W-1:0]   cdb0_tag, cdb1_tag;
  logic [31:0]        cdb0_value, cdb1_value;
  logic [ENTRY_W-1:0] fu0_entry, fu1_entry;
  logic               fu0_enable, fu1_enable;

  issue_queue #(.IQ_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_entry(dispatch_entry),
    .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
    .iq_full(iq_full), .iq_count(iq_count),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_value(cdb0_value),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
    .fu0_entry(fu0_entry), .fu1_entry(fu1_entry),
    .fu0_enable(fu0_enable), .fu1_enable(fu1_enable)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mon_en   = 0;

  task automatic chk(input string name, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int cyc; logic [ENTRY_W-1:0] e; } exp_t;
  exp_t q0[$], q1[$];

  logic [ENTRY_W-1:0] m_pay [8];
  bit                 m_v [8], m_r1 [8], m_r2 [8];
  int                 m_seq [8];
  int                 seq_ctr = 0;
  int                 m_count = 0;

  function automatic int key(input int i);
`ifdef IQ_AGE_SELECT_EN
    return m_seq[i];
`else
    return i;
`endif
  endfunction

  task automatic m_wake(input int i);
    if (!m_r1[i]) begin
      if (cdb0_valid && cdb0_tag == m_pay[i][115:110]) begin m_pay[i][109:78] = cdb0_value; m_r1[i] = 1; end
      else if (cdb1_valid && cdb1_tag == m_pay[i][115:110]) begin m_pay[i][109:78] = cdb1_value; m_r1[i] = 1; end
    end
    if (!m_r2[i]) begin
      if (cdb0_valid && cdb0_tag == m_pay[i][77:72]) begin m_pay[i][71:40] = cdb0_value; m_r2[i] = 1; end
      else if (cdb1_valid && cdb1_tag == m_pay[i][77:72]) begin m_pay[i][71:40] = cdb1_value; m_r2[i] = 1; end
    end
  endtask

  always @(posedge clk) begin
    int w0, w1, fs, ni;
    logic [ENTRY_W-1:0] e;
    cyc++;
    if (rst || flush) begin
      for (int i = 0; i < 8; i++) m_v[i] = 0;
      m_count = 0;
    end else begin
      w0 = -1; w1 = -1;
      for (int i = 0; i < 8; i++) begin
        if (m_v[i] && m_r1[i] && m_r2[i]) begin
          if (w0 < 0 || key(i) < key(w0)) begin w1 = w0; w0 = i; end
          else if (w1 < 0 || key(i) < key(w1)) w1 = i;
        end
      end
      fs = -1;
      for (int i = 7; i >= 0; i--) if (!m_v[i]) fs = i;
      ni = 0;
      if (w0 >= 0) begin e = m_pay[w0]; e[1:0] = 2'd0; q0.push_back('{cyc, e}); m_v[w0] = 0; ni++; end
      if (w1 >= 0) begin e = m_pay[w1]; e[1:0] = 2'd1; q1.push_back('{cyc, e}); m_v[w1] = 0; ni++; end
      for (int i = 0; i < 8; i++) if (m_v[i]) m_wake(i);
      if (dispatch_valid && fs >= 0) begin
        m_pay[fs] = dispatch_entry;
        m_r1[fs]  = dispatch_rs1_ready;
        m_r2[fs]  = dispatch_rs2_ready;
        m_v[fs]   = 1;
        m_seq[fs] = seq_ctr++;
        m_wake(fs);
        m_count++;
      end
      m_count -= ni;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t x;
    if (mon_en) begin
      chk("iq_count", iq_count, m_count);
      chk("iq_full", iq_full, m_count == 8);
      if (fu0_enable || (q0.size() > 0 && q0[0].cyc <= cyc)) begin
        if (q0.size() == 0) chk("fu0_unexpected_issue", fu0_enable, 0);
        else begin
          x = q0.pop_front();
          chk("fu0_enable", fu0_enable, 1);
          chk("fu0_issue_cycle", cyc, x.cyc);
          if (fu0_enable) chk("fu0_entry", fu0_entry, x.e);
        end
      end
      if (fu1_enable || (q1.size() > 0 && q1[0].cyc <= cyc)) begin
        if (q1.size() == 0) chk("fu1_unexpected_issue", fu1_enable, 0);
        else begin
          x = q1.pop_front();
          chk("fu1_enable", fu1_enable, 1);
          chk("fu1_issue_cycle", cyc, x.cyc);
          if (fu1_enable) chk("fu1_entry", fu1_entry, x.e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [ENTRY_W-1:0] mk(input logic [5:0] rs1t, input logic [31:0] rs1v,
                                            input logic [5:0] rs2t, input logic [31:0] rs2v,
                                            input logic [5:0] rob);
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[OPCODE_MSB:OPCODE_LSB] = 7'h33;
    e[PRD_MSB:PRD_LSB]       = 6'd50;
    e[PRS1_MSB:PRS1_LSB]     = rs1t;
    e[RS1V_MSB:RS1V_LSB]     = rs1v;
    e[PRS2_MSB:PRS2_LSB]     = rs2t;
    e[RS2V_MSB:RS2V_LSB]     = rs2v;
    e[IMM_MSB:IMM_LSB]       = 32'h1234;
    e[ROB_MSB:ROB_LSB]       = rob;
    e[FU_SEL_MSB:FU_SEL_LSB] = 2'd3;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    rst = 0; flush = 0; dispatch_valid = 0; cdb0_valid = 0; cdb1_valid = 0;
  endtask

  task automatic disp(input logic [ENTRY_W-1:0] e, input logic r1, input logic r2);
    dispatch_valid = 1; dispatch_entry = e; dispatch_rs1_ready = r1; dispatch_rs2_ready = r2;
  endtask

  task automatic cdb0(input logic [5:0] t, input logic [31:0] v);
    cdb0_valid = 1; cdb0_tag = t; cdb0_value = v;
  endtask

  task automatic cdb1(input logic [5:0] t, input logic [31:0] v);
    cdb1_valid = 1; cdb1_tag = t; cdb1_value = v;
  endtask

  initial begin
    logic [159:0] r;
    rst = 1; flush = 0; dispatch_valid = 0; dispatch_entry = '0;
    dispatch_rs1_ready = 0; dispatch_rs2_ready = 0;
    cdb0_valid = 0; cdb0_tag = '0; cdb0_value = '0;
    cdb1_valid = 0; cdb1_tag = '0; cdb1_value = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    mon_en = 1;
    @(negedge clk);
    chk("reset_fu0_entry", fu0_entry, 0);
    chk("reset_fu1_entry", fu1_entry, 0);
    chk("reset_fu0_enable", fu0_enable, 0);
    chk("reset_fu1_enable", fu1_enable, 0);
    #1;

    // single ready ADD
    disp(mk(6'd1, 32'd5, 6'd2, 32'd7, 6'd1), 1, 1); step();
    repeat (3) step();

    // wait on tag 12, wake via cdb1
    disp(mk(6'd12, 32'h0, 6'd2, 32'd7, 6'd2), 0, 1); step();
    repeat (3) step();
    cdb1(6'd12, 32'hDEAD); step();
    repeat (3) step();

    // broadcast coincident with dispatch
    disp(mk(6'd9, 32'h0, 6'd3, 32'd1, 6'd3), 0, 1); cdb0(6'd9, 32'hBEEF); step();
    repeat (3) step();

    // fill all slots, overflow dispatch, dual wake
    for (int i = 0; i < 8; i++) begin
      disp(mk(6'(20 + i), 32'h0, 6'd2, 32'd7, 6'(i)), 0, 1); step();
    end
    disp(mk(6'd20, 32'h0, 6'd2, 32'd7, 6'd9), 0, 1); step();
    cdb0(6'd20, 32'hA0); cdb1(6'd21, 32'hA1); step();
    repeat (2) step();
    for (int i = 2; i < 8; i += 2) begin
      cdb0(6'(20 + i), 32'(i)); cdb1(6'(21 + i), 32'(i + 1)); step();
    end
    repeat (3) step();

    // ordering: A, B(ready), C; B issues; D reuses slot 1; wake A and D together
    disp(mk(6'd40, 32'h0, 6'd2, 32'd7, 6'd10), 0, 1); step();
    disp(mk(6'd1, 32'd3, 6'd2, 32'd4, 6'd11), 1, 1); step();
    disp(mk(6'd41, 32'h0, 6'd2, 32'd7, 6'd12), 0, 1); step();
    repeat (2) step();
    disp(mk(6'd40, 32'h0, 6'd2, 32'd7, 6'd13), 0, 1); step();
    cdb0(6'd40, 32'h4040); step();
    cdb1(6'd41, 32'h4141); step();
    repeat (3) step();

    // flush with 5 waiting entries and a concurrent dispatch
    for (int i = 0; i < 5; i++) begin
      disp(mk(6'(30 + i), 32'h0, 6'd2, 32'd7, 6'(20 + i)), 0, 1); step();
    end
    flush = 1; disp(mk(6'd1, 32'd1, 6'd2, 32'd2, 6'd30), 1, 1); step();
    for (int i = 0; i < 5; i += 2) begin
      cdb0(6'(30 + i), 32'h77); cdb1(6'(31 + i), 32'h78); step();
    end
    repeat (3) step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        r[PRS1_MSB:PRS1_LSB] = 6'($urandom_range(0, 15));
        r[PRS2_MSB:PRS2_LSB] = 6'($urandom_range(0, 15));
        disp(r[ENTRY_W-1:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 9) < 4) cdb0(6'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 9) < 4) cdb1(6'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 63) == 0) flush = 1;
      if ($urandom_range(0, 299) == 0) rst = 1;
      step();
    end

    flush = 1; step();
    repeat (3) step();
    chk("fu0_queue_drained", 139'(q0.size()), 0);
    chk("fu1_queue_drained", 139'(q1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
